// File: rtl/irb_pkg.sv
// Shared controller/DMA definitions: op codes, responder FSM states, region bases and lengths.
package irb_pkg;

  typedef enum logic [2:0] {
    OP_INF = 3'd0,
    OP_FMI = 3'd1,
    OP_KEX = 3'd2,
    OP_KPW = 3'd3,
    OP_KDW = 3'd4,
    OP_FMO = 3'd5
  } dma_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrFetch,
    StWrSend,
    StDone
  } dma_state_t;

  // Transfer counters; wide enough for the longest region transfer.
  localparam int unsigned CNT_W = 8;

  localparam logic [31:0] INF_BASE = 32'h0000_0000;
  localparam logic [31:0] FMI_BASE = 32'h0000_0100;
  localparam logic [31:0] KEX_BASE = 32'h0000_4000;
  localparam logic [31:0] KPW_BASE = 32'h0000_8000;
  localparam logic [31:0] KDW_BASE = 32'h0000_C000;
  localparam logic [31:0] FMO_BASE = 32'h0001_0000;

  localparam int unsigned INF_LEN = 2;
  localparam int unsigned FMI_LEN = 64;
  localparam int unsigned KEX_LEN = 96;
  localparam int unsigned KPW_LEN = 96;
  localparam int unsigned KDW_LEN = 9;
  localparam int unsigned FMO_LEN = 32;

  localparam logic [33:0] MEM_WORDS = 34'h0_0002_0000;

endpackage

// File: rtl/dma_addr_gen.sv
// Op -> region base/length lookup and start address; optional end-of-memory check under
// DMA_BOUNDS_CHECK_EN.
module dma_addr_gen
  import irb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [2:0]        op_i,
  input  logic [31:0]       off1_i,
  input  logic [31:0]       off2_i,
  output logic [ADDR_W-1:0] start_addr_o,
  output logic [CNT_W-1:0]  len_o,
  output logic              illegal_o,
  output logic              oob_o
);

  logic [31:0] base;

  always_comb begin
    base      = '0;
    len_o     = '0;
    illegal_o = 1'b0;
    case (dma_op_t'(op_i))
      OP_INF: begin base = INF_BASE; len_o = CNT_W'(INF_LEN); end
      OP_FMI: begin base = FMI_BASE; len_o = CNT_W'(FMI_LEN); end
      OP_KEX: begin base = KEX_BASE; len_o = CNT_W'(KEX_LEN); end
      OP_KPW: begin base = KPW_BASE; len_o = CNT_W'(KPW_LEN); end
      OP_KDW: begin base = KDW_BASE; len_o = CNT_W'(KDW_LEN); end
      OP_FMO: begin base = FMO_BASE; len_o = CNT_W'(FMO_LEN); end
      default: illegal_o = 1'b1;
    endcase
  end

  assign start_addr_o = ADDR_W'(base) + ADDR_W'(off1_i) + ADDR_W'(off2_i);

`ifdef DMA_BOUNDS_CHECK_EN
  // Extra headroom bits so a huge offset cannot wrap past the limit.
  logic [33:0] end_word;
  assign end_word = 34'(base) + 34'(off1_i) + 34'(off2_i) + 34'(len_o);
  assign oob_o    = !illegal_o && (end_word > MEM_WORDS);
`else
  assign oob_o = 1'b0;
`endif

endmodule

// File: rtl/dma_responder.sv
// Responder end of the controller->DMA command interface: memory->buffer reads (op0-4) and
// output buffer->memory writes (op5). Bounds checking is enabled by DMA_BOUNDS_CHECK_EN.
module dma_responder
  import irb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BUF_AW  = 12,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              s_dma_i,
  input  logic [2:0]        dma_op_i,
  input  logic [31:0]       dma_info1_i,
  input  logic [31:0]       dma_info2_i,
  input  logic [31:0]       dma_mem_info1_i,
  input  logic [31:0]       dma_mem_info2_i,
  output logic              f_dma_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [63:0]       inf_conv_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              buf_we_o,
  output logic              buf_re_o,
  output logic [2:0]        buf_sel_o,
  output logic [BUF_AW-1:0] buf_addr_o,
  output logic [DATA_W-1:0] buf_wdata_o,
  input  logic [DATA_W-1:0] buf_rdata_i,
  output logic [31:0]       buf_tag1_o,
  output logic [31:0]       buf_tag2_o
);

  dma_state_t        state_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  len_q, issued_q, returned_q;
  logic [DATA_W-1:0] wdata_q;
  logic              send_first_q;
  logic              f_dma_q, err_q;
  logic [63:0]       inf_q;
  logic [31:0]       tag1_q, tag2_q;

  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  op_len;
  logic              op_illegal, op_oob;
  logic              rd_req;

  dma_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .op_i        (dma_op_i),
    .off1_i      (dma_mem_info1_i),
    .off2_i      (dma_mem_info2_i),
    .start_addr_o(start_addr),
    .len_o       (op_len),
    .illegal_o   (op_illegal),
    .oob_o       (op_oob)
  );

  // Outstanding limit works off the registered counts only.
  assign rd_req = (state_q == StRd) && (issued_q < len_q) &&
                  ((issued_q - returned_q) < CNT_W'(MAX_OUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      op_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      returned_q   <= '0;
      wdata_q      <= '0;
      send_first_q <= 1'b0;
      f_dma_q      <= 1'b0;
      err_q        <= 1'b0;
      inf_q        <= '0;
      tag1_q       <= '0;
      tag2_q       <= '0;
    end else begin
      f_dma_q <= 1'b0;
      if (s_dma_i && (state_q != StIdle)) err_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (s_dma_i) begin
            op_q       <= dma_op_i;
            tag1_q     <= dma_info1_i;
            tag2_q     <= dma_info2_i;
            addr_q     <= start_addr;
            len_q      <= op_len;
            issued_q   <= '0;
            returned_q <= '0;
            if (op_illegal || op_oob) begin
              err_q   <= 1'b1;
              state_q <= StDone;
            end else if (dma_op_i == OP_FMO) begin
              state_q <= StWrFetch;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          if (rd_req && mem_gnt_i) begin
            issued_q <= issued_q + 1'b1;
            addr_q   <= addr_q + 1'b1;
          end
          if (mem_rvalid_i) begin
            returned_q <= returned_q + 1'b1;
            if (op_q == OP_INF) begin
              if (returned_q[0]) inf_q[63:32] <= mem_rdata_i[31:0];
              else               inf_q[31:0]  <= mem_rdata_i[31:0];
            end
            if ((returned_q + 1'b1) == len_q) state_q <= StDone;
          end
        end
        StWrFetch: begin
          send_first_q <= 1'b1;
          state_q      <= StWrSend;
        end
        StWrSend: begin
          send_first_q <= 1'b0;
          if (send_first_q) wdata_q <= buf_rdata_i;
          if (mem_gnt_i) begin
            issued_q <= issued_q + 1'b1;
            addr_q   <= addr_q + 1'b1;
            state_q  <= ((issued_q + 1'b1) == len_q) ? StDone : StWrFetch;
          end
        end
        StDone: begin
          f_dma_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    buf_we_o    = 1'b0;
    buf_re_o    = 1'b0;
    buf_addr_o  = '0;
    buf_wdata_o = '0;
    case (state_q)
      StRd: begin
        mem_req_o = rd_req;
        if (mem_rvalid_i && (op_q != OP_INF)) begin
          buf_we_o    = 1'b1;
          buf_addr_o  = BUF_AW'(returned_q);
          buf_wdata_o = mem_rdata_i;
        end
      end
      StWrFetch: begin
        buf_re_o   = 1'b1;
        buf_addr_o = BUF_AW'(issued_q);
      end
      StWrSend: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        // Read data is only on the bus during the first send cycle; the stage holds it after.
        mem_wdata_o = send_first_q ? buf_rdata_i : wdata_q;
      end
      default: ;
    endcase
  end

  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q != StIdle);
  assign f_dma_o    = f_dma_q;
  assign err_o      = err_q;
  assign inf_conv_o = inf_q;
  assign buf_sel_o  = op_q;
  assign buf_tag1_o = tag1_q;
  assign buf_tag2_o = tag2_q;

endmodule

// File: tb/tb_dma_responder.sv
// Directed bench for dma_responder with a memory responder model (grant stalls, read latency)
// and a 1-cycle-latency output buffer model.
module tb_dma_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_dma = 1'b0;
  logic [2:0]  dma_op = '0;
  logic [31:0] dma_info1 = '0, dma_info2 = '0, dma_mem_info1 = '0, dma_mem_info2 = '0;
  logic        f_dma, busy, err;
  logic [63:0] inf_conv;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        buf_we, buf_re;
  logic [2:0]  buf_sel;
  logic [11:0] buf_addr;
  logic [31:0] buf_wdata;
  logic [31:0] buf_rdata = '0;
  logic [31:0] buf_tag1, buf_tag2;

  always #5 clk = ~clk;

  dma_responder #(
    .ADDR_W (32),
    .DATA_W (32),
    .BUF_AW (12),
    .MAX_OUT(4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .s_dma_i        (s_dma),
    .dma_op_i       (dma_op),
    .dma_info1_i    (dma_info1),
    .dma_info2_i    (dma_info2),
    .dma_mem_info1_i(dma_mem_info1),
    .dma_mem_info2_i(dma_mem_info2),
    .f_dma_o        (f_dma),
    .busy_o         (busy),
    .err_o          (err),
    .inf_conv_o     (inf_conv),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata),
    .buf_we_o       (buf_we),
    .buf_re_o       (buf_re),
    .buf_sel_o      (buf_sel),
    .buf_addr_o     (buf_addr),
    .buf_wdata_o    (buf_wdata),
    .buf_rdata_i    (buf_rdata),
    .buf_tag1_o     (buf_tag1),
    .buf_tag2_o     (buf_tag2)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'd0) return 32'h0102_0304;
    if (a == 32'd1) return 32'h0000_0203;
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  function automatic logic [31:0] obuf(input logic [31:0] idx);
    return 32'hC0DE_0000 ^ (idx * 32'd7);
  endfunction

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } rd_t;

  rd_t         rq[$];
  int unsigned cyc = 0, t0 = 0, f_cyc = 0;
  int          lat = 1, stall_n = 0, stall_ctr = 0;
  logic        rd_pend = 1'b0;
  logic [11:0] rd_pend_addr = '0;

  int          fcnt, req_cyc, outst, max_out;
  int          bw_cnt, bw_err, rd_cnt, rd_addr_err, wr_cnt, wr_err, stab_err;
  logic [31:0] exp_rd_addr, exp_wr_addr, exp_buf_base;
  logic [2:0]  exp_sel;
  logic        prev_stall;
  logic [31:0] p_addr, p_wdata;
  logic        p_we;

  // Input drive, just after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = memval(rq[0].addr);
      rq.delete(0);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    if (rd_pend) buf_rdata = obuf({20'd0, rd_pend_addr});
    mem_gnt = mem_req && (stall_ctr >= stall_n);
  end

  // Output observation, on the falling edge.
  always @(negedge clk) begin
    if (f_dma) begin fcnt++; f_cyc = cyc; end
    if (mem_req) req_cyc++;
    if (mem_rvalid) outst--;
    if (mem_req) begin
      if (prev_stall && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
        stab_err++;
      if (mem_gnt) begin
        stall_ctr  = 0;
        prev_stall = 1'b0;
        if (mem_we) begin
          if (mem_addr !== exp_wr_addr || mem_wdata !== obuf(exp_wr_addr - 32'h1_0000)) wr_err++;
          exp_wr_addr++;
          wr_cnt++;
        end else begin
          if (mem_addr !== exp_rd_addr) rd_addr_err++;
          exp_rd_addr++;
          rd_cnt++;
          rq.push_back('{cyc + lat, mem_addr});
          outst++;
        end
      end else begin
        stall_ctr++;
        prev_stall = 1'b1;
        p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
      end
    end else if (prev_stall) begin
      stab_err++;
      prev_stall = 1'b0;
    end
    if (outst > max_out) max_out = outst;
    if (buf_we) begin
      if (buf_addr !== bw_cnt[11:0] || buf_sel !== exp_sel ||
          buf_wdata !== memval(exp_buf_base + bw_cnt)) bw_err++;
      bw_cnt++;
    end
    rd_pend      = buf_re;
    rd_pend_addr = buf_addr;
  end

  task automatic clr_mon();
    fcnt = 0; req_cyc = 0; outst = 0; max_out = 0;
    bw_cnt = 0; bw_err = 0; rd_cnt = 0; rd_addr_err = 0; wr_cnt = 0; wr_err = 0; stab_err = 0;
    prev_stall = 1'b0; stall_ctr = 0;
    exp_rd_addr = '0; exp_wr_addr = '0; exp_buf_base = '0; exp_sel = '0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    rq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clr_mon();
  endtask

  task automatic start_cmd(input logic [2:0] op, input logic [31:0] i1, input logic [31:0] i2,
                           input logic [31:0] mi1, input logic [31:0] mi2);
    @(posedge clk); #1;
    dma_op = op; dma_info1 = i1; dma_info2 = i2; dma_mem_info1 = mi1; dma_mem_info2 = mi2;
    s_dma = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    s_dma = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fcnt > 0) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({f_dma, busy, err, mem_req, mem_we, buf_we, buf_re} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0", {f_dma, busy, err, mem_req, mem_we, buf_we, buf_re});
    end
    checks++;
    if ({inf_conv, mem_addr, mem_wdata} !== 128'd0) begin
      failures++;
      $display("FAIL reset_data: got %h %h %h want 0", inf_conv, mem_addr, mem_wdata);
    end
    checks++;
    if ({buf_sel, buf_addr, buf_wdata, buf_tag1, buf_tag2} !== 111'd0) begin
      failures++;
      $display("FAIL reset_buf: got %h %h %h %h %h want 0", buf_sel, buf_addr, buf_wdata, buf_tag1,
               buf_tag2);
    end
    #1 rst_n = 1'b1;
    clr_mon();
  endtask

  task automatic test_inf();
    bit ok;
    apply_reset();
    lat = 1; stall_n = 0;
    start_cmd(3'd0, 32'hAAAA_0001, 32'h5555_0002, 32'd0, 32'd0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL inf_busy: got %b want 1", busy); end
    wait_done(50, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL inf_done: got %b want 1", ok); end
    checks++;
    if (inf_conv !== 64'h0000_0203_0102_0304) begin
      failures++; $display("FAIL inf_conv: got %h want 0000020301020304", inf_conv);
    end
    checks++;
    if ((f_cyc - t0) !== 5) begin failures++; $display("FAIL inf_latency: got %0d want 5", f_cyc - t0); end
    checks++;
    if (fcnt !== 1) begin failures++; $display("FAIL inf_fcnt: got %0d want 1", fcnt); end
    checks++;
    if (bw_cnt !== 0) begin failures++; $display("FAIL inf_no_bufwe: got %0d want 0", bw_cnt); end
    checks++;
    if ({buf_tag1, buf_tag2} !== 64'hAAAA_0001_5555_0002) begin
      failures++; $display("FAIL inf_tags: got %h %h want aaaa0001 55550002", buf_tag1, buf_tag2);
    end
    checks++;
    if ({busy, err} !== 2'b00) begin failures++; $display("FAIL inf_idle: got %b want 00", {busy, err}); end
  endtask

  task automatic test_fmi();
    bit ok;
    apply_reset();
    lat = 2; stall_n = 0;
    exp_rd_addr = 32'h118; exp_buf_base = 32'h118; exp_sel = 3'd1;
    start_cmd(3'd1, 32'd0, 32'd0, 32'd8, 32'd16);
    wait_done(400, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL fmi_done: got %b want 1", ok); end
    checks++;
    if (bw_cnt !== 64) begin failures++; $display("FAIL fmi_bufwe_cnt: got %0d want 64", bw_cnt); end
    checks++;
    if (bw_err !== 0) begin failures++; $display("FAIL fmi_bufwe_data: got %0d errs want 0", bw_err); end
    checks++;
    if (rd_cnt !== 64 || rd_addr_err !== 0) begin
      failures++; $display("FAIL fmi_reads: got %0d/%0d want 64/0", rd_cnt, rd_addr_err);
    end
    checks++;
    if (exp_rd_addr !== 32'h158) begin
      failures++; $display("FAIL fmi_last_addr: got %h want 158", exp_rd_addr);
    end
    checks++;
    if (max_out > 4) begin failures++; $display("FAIL fmi_outstanding: got %0d want <=4", max_out); end
    checks++;
    if ({fcnt, err} !== {32'd1, 1'b0}) begin
      failures++; $display("FAIL fmi_fdone_err: got %0d %b want 1 0", fcnt, err);
    end
  endtask

  task automatic test_fmo();
    bit ok;
    apply_reset();
    lat = 1; stall_n = 3;
    exp_wr_addr = 32'h1_0000;
    start_cmd(3'd5, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done(600, ok);
    stall_n = 0;
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL fmo_done: got %b want 1", ok); end
    checks++;
    if (wr_cnt !== 32) begin failures++; $display("FAIL fmo_writes: got %0d want 32", wr_cnt); end
    checks++;
    if (wr_err !== 0) begin failures++; $display("FAIL fmo_addr_data: got %0d errs want 0", wr_err); end
    checks++;
    if (stab_err !== 0) begin failures++; $display("FAIL fmo_stable: got %0d errs want 0", stab_err); end
    checks++;
    if (req_cyc !== 128) begin failures++; $display("FAIL fmo_req_cycles: got %0d want 128", req_cyc); end
    checks++;
    if ({fcnt, bw_cnt} !== {32'd1, 32'd0}) begin
      failures++; $display("FAIL fmo_fdone: got %0d %0d want 1 0", fcnt, bw_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    lat = 6; stall_n = 0;
    exp_rd_addr = 32'h4000; exp_buf_base = 32'h4000; exp_sel = 3'd2;
    start_cmd(3'd2, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (10) @(posedge clk);
    start_cmd(3'd1, 32'd0, 32'd0, 32'd0, 32'd0);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL b2b_err: got %b want 1", err); end
    wait_done(1000, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b want 1", ok); end
    repeat (10) @(negedge clk);
    checks++;
    if (fcnt !== 1) begin failures++; $display("FAIL b2b_fcnt: got %0d want 1", fcnt); end
    checks++;
    if (bw_cnt !== 96 || bw_err !== 0) begin
      failures++; $display("FAIL b2b_transfer: got %0d/%0d want 96/0", bw_cnt, bw_err);
    end
    checks++;
    if (max_out !== 4) begin failures++; $display("FAIL b2b_max_out: got %0d want 4", max_out); end
  endtask

  task automatic test_illegal();
    bit ok;
    apply_reset();
    lat = 1; stall_n = 0;
    start_cmd(3'd7, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done(20, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL ill_done: got %b want 1", ok); end
    checks++;
    if ((f_cyc - t0) !== 2) begin failures++; $display("FAIL ill_latency: got %0d want 2", f_cyc - t0); end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL ill_err: got %b want 1", err); end
    checks++;
    if (req_cyc !== 0) begin failures++; $display("FAIL ill_no_req: got %0d want 0", req_cyc); end
  endtask

  task automatic test_bounds();
    bit ok;
    apply_reset();
    lat = 1; stall_n = 0;
    exp_rd_addr = 32'h2_0000; exp_buf_base = 32'h2_0000; exp_sel = 3'd4;
    start_cmd(3'd4, 32'd0, 32'd0, 32'h1_4000, 32'd0);
    wait_done(100, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL bnd_done: got %b want 1", ok); end
`ifdef DMA_BOUNDS_CHECK_EN
    checks++;
    if ({err, req_cyc} !== {1'b1, 32'd0}) begin
      failures++; $display("FAIL bnd_reject: got err=%b req=%0d want 1 0", err, req_cyc);
    end
    checks++;
    if ((f_cyc - t0) !== 2) begin failures++; $display("FAIL bnd_latency: got %0d want 2", f_cyc - t0); end
`else
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL bnd_err: got %b want 0", err); end
    checks++;
    if (bw_cnt !== 9 || bw_err !== 0) begin
      failures++; $display("FAIL bnd_transfer: got %0d/%0d want 9/0", bw_cnt, bw_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bw_snap;
    apply_reset();
    lat = 2; stall_n = 0;
    exp_rd_addr = 32'h8000; exp_buf_base = 32'h8000; exp_sel = 3'd3;
    start_cmd(3'd3, 32'h1234_5678, 32'd9, 32'd0, 32'd0);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    bw_snap = bw_cnt;
    checks++;
    if ({mem_req, busy, buf_we, buf_re, f_dma, err, buf_sel, buf_tag1, mem_addr} !== 73'd0) begin
      failures++;
      $display("FAIL mid_reset_outs: got %b %b %b %h %h want 0", mem_req, busy, buf_we, buf_tag1,
               mem_addr);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (bw_cnt !== bw_snap) begin
      failures++; $display("FAIL mid_late_rvalid: got %0d want %0d", bw_cnt, bw_snap);
    end
    clr_mon();
    lat = 1;
    start_cmd(3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done(50, ok);
    checks++;
    if (ok !== 1'b1 || fcnt !== 1) begin
      failures++; $display("FAIL mid_new_op: got done=%b f=%0d want 1 1", ok, fcnt);
    end
    checks++;
    if (inf_conv !== 64'h0000_0203_0102_0304) begin
      failures++; $display("FAIL mid_inf_conv: got %h want 0000020301020304", inf_conv);
    end
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_inf();
    test_fmi();
    test_fmo();
    test_back_to_back();
    test_illegal();
    test_bounds();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
